// File: rtl/cr_kme_body_param.sv
// -----------------------------------------------------------------------------
// cr_kme_body_param
//   Shared parameter helpers for the KME key-op width converters.
//   - lane_width(ratio): width of a lane count that must represent 0..ratio.
//     The downsizer uses the same helper.
//   - upsizer_params_ok(in_w, ratio): legal-range test for the upsizer
//     parameters. The instantiating module turns a false result into an
//     elaboration-time $error.
// -----------------------------------------------------------------------------
package cr_kme_body_param;

    function automatic int lane_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic bit upsizer_params_ok(input int in_w, input int ratio);
        return (ratio >= 2) && (in_w >= 8);
    endfunction

endpackage

// File: rtl/cr_kme_kop_upsizer_hold.sv
// -----------------------------------------------------------------------------
// cr_kme_kop_upsizer_hold
//   Single-entry valid/stall holding register. A loaded entry stays stable
//   until the downstream takes it (out_valid & ~out_stall).
//
//   Callers must only assert load when the slot is empty or draining in the
//   same cycle, i.e. when ~(out_valid & out_stall). When a drain and a load
//   happen in the same cycle, the entry is replaced with no bubble.
//
//   The data is cleared by reset only. It is not cleared on drain, so that
//   callers can reuse the previous entry's contents.
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   load       in   write load_data into the slot (marks it valid)
//   load_data  in   W-bit entry
//   out_stall  in   downstream cannot take the entry this cycle
//   out_valid  out  slot holds an entry
//   out_data   out  held entry (registered)
// -----------------------------------------------------------------------------
module cr_kme_kop_upsizer_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_stall,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (!out_stall) begin
            // The entry (if any) transfers this cycle.
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;

endmodule

// File: rtl/cr_kme_kop_upsizer_xn.sv
// -----------------------------------------------------------------------------
// cr_kme_kop_upsizer_xn
//   Packs RATIO consecutive IN_DATA_SIZE-bit beats into one OUT_DATA_SIZE-bit
//   word. Beat k of a word goes to lane k; lane 0 is bits [IN_DATA_SIZE-1:0].
//   An eof beat completes the word early. The next frame then starts at
//   lane 0.
//
//   The completed word is valid on the cycle after its completing beat.
//   Throughput is one beat per cycle. The held word can drain and be
//   reloaded in the same cycle.
//
// Build option
//   KME_UPSIZER_ZERO_FILL_EN
//     defined   : unused lanes of a short word are zero, and the accumulation
//                 lanes clear whenever a word completes.
//     undefined : unused lanes of a short word keep the previous word's lane
//                 contents. Consumers must qualify the data with
//                 upsizer_out_num_lanes.
//
// Ports
//   clk                    in   clock
//   rst_n                  in   synchronous active-low reset
//   in_upsizer_valid       in   input beat present
//   in_upsizer_eof         in   beat is last of its frame
//   in_upsizer_data        in   beat payload
//   upsizer_in_stall       out  upstream must hold off (combinational)
//   upsizer_out_valid      out  output word present
//   upsizer_out_eof        out  word holds the last beat of a frame
//   upsizer_out_num_lanes  out  valid lanes in the word (1..RATIO)
//   upsizer_out_data       out  packed word
//   out_upsizer_stall      in   downstream cannot take a word this cycle
// -----------------------------------------------------------------------------
module cr_kme_kop_upsizer_xn
    import cr_kme_body_param::*;
#(
    parameter  int IN_DATA_SIZE  = 128,
    parameter  int RATIO         = 2,
    localparam int OUT_DATA_SIZE = IN_DATA_SIZE * RATIO,
    localparam int LANE_W        = lane_width(RATIO)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_upsizer_valid,
    input  logic                     in_upsizer_eof,
    input  logic [IN_DATA_SIZE-1:0]  in_upsizer_data,
    output logic                     upsizer_in_stall,
    output logic                     upsizer_out_valid,
    output logic                     upsizer_out_eof,
    output logic [LANE_W-1:0]        upsizer_out_num_lanes,
    output logic [OUT_DATA_SIZE-1:0] upsizer_out_data,
    input  logic                     out_upsizer_stall
);

    localparam int HOLD_W = OUT_DATA_SIZE + LANE_W + 1;

    generate
        if (!upsizer_params_ok(IN_DATA_SIZE, RATIO)) begin : g_param_err
            $error("cr_kme_kop_upsizer_xn: need RATIO >= 2 and IN_DATA_SIZE >= 8");
        end
    endgenerate

    logic [LANE_W-1:0]                   lane_reg;
    logic [LANE_W-1:0]                   lane_next;
    logic                                accept;
    logic                                last_lane;
    logic                                complete;
    logic [RATIO-1:0][IN_DATA_SIZE-1:0]  word_next;
    logic [RATIO-1:0][IN_DATA_SIZE-1:0]  stale_lanes;
    logic [HOLD_W-1:0]                   hold_in;
    logic [HOLD_W-1:0]                   hold_out;

    // Every beat is gated by the stall, so a held-and-stalled word freezes
    // the accumulation as well.
    assign upsizer_in_stall = upsizer_out_valid & out_upsizer_stall;
    assign accept           = in_upsizer_valid & ~upsizer_in_stall;
    assign last_lane        = (lane_reg == LANE_W'(RATIO - 1));
    assign complete         = accept & (last_lane | in_upsizer_eof);
    assign stale_lanes      = upsizer_out_data;

    always_comb begin
        lane_next = lane_reg;
        if (complete) begin
            lane_next = '0;
        end else if (accept) begin
            lane_next = lane_reg + LANE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_reg <= '0;
        end else begin
            lane_reg <= lane_next;
        end
    end

    // Per-lane assembly of the word being completed. Lanes below lane_reg come
    // from the accumulation, the current lane comes from the incoming beat,
    // and lanes above it are fill. The top lane is only ever written by a
    // completing beat, so it has no accumulation storage.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            logic [IN_DATA_SIZE-1:0] fill;
`ifdef KME_UPSIZER_ZERO_FILL_EN
            assign fill = '0;
`else
            // Reuse what the holding register already carries, so the
            // short-word upper lanes need no extra muxing or clearing.
            assign fill = stale_lanes[gi];
`endif
            if (gi < RATIO - 1) begin : g_acc
                logic [IN_DATA_SIZE-1:0] acc_reg;
                logic [IN_DATA_SIZE-1:0] lane_word;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        acc_reg <= '0;
`ifdef KME_UPSIZER_ZERO_FILL_EN
                    end else if (complete) begin
                        acc_reg <= '0;
`endif
                    end else if (accept && (lane_reg == LANE_W'(gi))) begin
                        acc_reg <= in_upsizer_data;
                    end
                end

                always_comb begin
                    lane_word = fill;
                    if (LANE_W'(gi) < lane_reg) begin
                        lane_word = acc_reg;
                    end else if (LANE_W'(gi) == lane_reg) begin
                        lane_word = in_upsizer_data;
                    end
                end

                assign word_next[gi] = lane_word;
            end else begin : g_top
                assign word_next[gi] = last_lane ? in_upsizer_data : fill;
            end
        end
    endgenerate

    assign hold_in = {in_upsizer_eof, lane_reg + LANE_W'(1), word_next};

    cr_kme_kop_upsizer_hold #(
        .W (HOLD_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_data (hold_in),
        .out_stall (out_upsizer_stall),
        .out_valid (upsizer_out_valid),
        .out_data  (hold_out)
    );

    assign {upsizer_out_eof, upsizer_out_num_lanes, upsizer_out_data} = hold_out;

endmodule

// File: doc/cr_kme_kop_upsizer_xn.md
# cr_kme_kop_upsizer_xn

Parametrised stream upsizer for the KME key-op datapath: packs RATIO consecutive IN_DATA_SIZE-bit beats into one RATIO*IN_DATA_SIZE-bit word, with early completion on end-of-frame. It generalises the fixed 2:1 upsizer that feeds the KDF key filter and adds two things:
- a valid-lane count on the output;
- full one-beat-per-cycle throughput under downstream stall.

It sits between the GCM key output and any wide consumer (key filter, hash key path) using the team's valid/stall handshake.

## Interface
- IN_DATA_SIZE, default 128: input beat width in bits, must be ≥ 8.
- RATIO, default 2: input beats per output word, must be ≥ 2.
- OUT_DATA_SIZE, derived as IN_DATA_SIZE*RATIO: output word width. Localparam, not overridable.
- LANE_W, derived as $clog2(RATIO+1): width of the lane count. Localparam.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_upsizer_valid  in  1  input beat present.
- in_upsizer_eof  in  1  beat is the last of its frame.
- in_upsizer_data  in  IN_DATA_SIZE  beat payload.
- upsizer_in_stall  out  1  upstream must not present beats while high.
- upsizer_out_valid  out  1  output word present.
- upsizer_out_eof  out  1  word holds the last beat of a frame.
- upsizer_out_num_lanes  out  LANE_W  valid lanes in the word, range 1..RATIO.
- upsizer_out_data  out  OUT_DATA_SIZE  packed word.
- out_upsizer_stall  in  1  downstream cannot take a word this cycle.

## Operation
- Input accept: in_upsizer_valid=1 and upsizer_in_stall=0. A beat presented while stall=1 is a protocol violation; behaviour is undefined and no detection is provided.
- Output transfer: upsizer_out_valid=1 and out_upsizer_stall=0. While the word is held, valid, eof, num_lanes and data stay stable.
- Lane order: the first beat of a word goes in bits [IN_DATA_SIZE-1:0]; beat k goes in lane k.
- State: accumulation register (RATIO-1 lanes), lane counter lane_q (0..RATIO-1), output holding register plus valid flag.
- Completion: an accepted beat completes a word when lane_q==RATIO-1 or when in_upsizer_eof=1. On completion:
  - accumulated lanes and the current beat load into the holding register;
  - num_lanes = lane_q+1;
  - eof = in_upsizer_eof;
  - lane_q returns to 0.
- An accepted beat that does not complete a word is written to lane lane_q, and lane_q increments.
- Short words: on an eof word with num_lanes<RATIO, the unused upper lanes follow the Configuration section.
- Frames are independent. A new frame always starts at lane 0.
- upsizer_in_stall = upsizer_out_valid & out_upsizer_stall. This is combinational from out_upsizer_stall.
- Same-cycle drain and load: the held word transfers, and a completing beat reloads the holding register in the same cycle, so there is no bubble.

## Timing
- Reset values (rst_n=0 at a clock edge): upsizer_out_valid=0, upsizer_out_eof=0, upsizer_out_num_lanes=0, upsizer_out_data=0, lane_q=0, accumulation register=0. upsizer_in_stall is then 0.
- Reset mid-operation discards any partial word and any held word. The upstream frame must restart.
- Latency: the output word is valid on the cycle after its completing beat is accepted.
- Throughput: with out_upsizer_stall=0, one beat per cycle indefinitely and one word per RATIO beats. An eof beat shortens that word.
- Back-pressure: once a word is held and out_upsizer_stall=1, stall is asserted in the same cycle. Partial accumulation is not blocked beyond this, because stall gates all input.
- RATIO=2 with the macro off is beat-for-beat identical to the legacy 2:1 upsizer, apart from the added num_lanes port.

## Configuration
- KME_UPSIZER_ZERO_FILL_EN defined: unused lanes of a short eof word are driven to zero. In addition, the accumulation register clears to zero whenever a word completes.
- Not defined: unused lanes carry stale accumulation contents, which saves the clear logic. Consumers must then qualify data with upsizer_out_num_lanes.

## Structure
- Shared package (cr_kme_body_param.v) holds:
  - the parameter range checks, as an elaborate-time $error for RATIO<2 or IN_DATA_SIZE<8;
  - a LANE_W helper function, reused by the downsizer.
- One sub-module is natural: cr_kme_kop_upsizer_hold, a single-entry valid/stall holding register parametrised on width. The lane packing, counter and completion logic stay in the top.

## Test plan
- IN=32, RATIO=4, no stall; beats 0x11,0x22,0x33,0x44 with eof on the 4th → one word, data 0x00000044_00000033_00000022_00000011, num_lanes=4, eof=1, valid one cycle after the 4th accept.
- IN=32, RATIO=4; beats 0xA,0xB with eof on 0xB → num_lanes=2, eof=1. With the macro on, the upper 64 bits are 0. With it off, they equal the previous word's lanes 2-3.
- Continuous 4096 beats, random eof, out_upsizer_stall=0 → no stall cycles, and word count and lane totals match a reference model.
- Hold out_upsizer_stall=1 for 10 cycles while a word is held → upsizer_in_stall=1 for those cycles, the word stays stable, and no beat is lost. Release → the held word transfers and the next completing beat loads in the same cycle.
- Assert rst_n=0 after 2 of 4 beats → all outputs are 0 the next cycle. A following 4-beat frame produces one word containing only post-reset beats.
- RATIO=2, IN=128, single-beat eof frames back-to-back → one word per cycle, num_lanes=1, eof=1 on each.
